// File: rtl/rgb_layer_mixer.sv
// rgb_layer_mixer: two-stage rectangle-object compositor with shadow/active object tables.
// Gradient object mode is compiled in only when RGB_MIXER_GRADIENT_EN is defined.
module rgb_layer_mixer #(
  parameter int NUM_OBJ = 4,
  parameter int COORD_W = 11,
  parameter int COLOR_W = 4,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = {COLOR_W'(16), COLOR_W'(8), COLOR_W'(0)},
  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COORD_W-1:0]     Cx,
  input  logic [COORD_W-1:0]     Cy,
  input  logic                   frame_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [COORD_W-1:0]     cfg_x,
  input  logic [COORD_W-1:0]     cfg_y,
  input  logic [COORD_W-1:0]     cfg_w,
  input  logic [COORD_W-1:0]     cfg_h,
  input  logic [3*COLOR_W-1:0]   cfg_color,
  input  logic                   cfg_mode,
  output logic                   out_valid,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B
);
  typedef struct packed {
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [COORD_W-1:0]   w;
    logic [COORD_W-1:0]   h;
    logic [3*COLOR_W-1:0] color;
`ifdef RGB_MIXER_GRADIENT_EN
    logic                 mode;
`endif
  } obj_t;

  obj_t                 shadow [NUM_OBJ];
  obj_t                 active [NUM_OBJ];
  obj_t                 wr_obj;
  logic [NUM_OBJ-1:0]   wr_sel;
  logic [NUM_OBJ-1:0]   hit;
  logic [3*COLOR_W-1:0] sel_color;
  logic [NUM_OBJ-1:0]   s1_hit;
  logic                 s1_en;
  logic [3*COLOR_W-1:0] s1_color;
  logic [3*COLOR_W-1:0] pix;
`ifdef RGB_MIXER_GRADIENT_EN
  logic [COORD_W-1:0]   sel_x, sel_y, s1_cx, s1_cy, s1_x, s1_y;
  logic                 sel_mode, s1_mode;
`else
  logic                 unused_mode;
  assign unused_mode = cfg_mode;
`endif

  always_comb begin
    wr_obj = '0;
    wr_obj.x = cfg_x;
    wr_obj.y = cfg_y;
    wr_obj.w = cfg_w;
    wr_obj.h = cfg_h;
    wr_obj.color = cfg_color;
`ifdef RGB_MIXER_GRADIENT_EN
    wr_obj.mode = cfg_mode;
`endif
    for (int i = 0; i < NUM_OBJ; i++) begin
      wr_sel[i] = cfg_valid && cfg_ready && cfg_idx == IDX_W'(i);
      hit[i] = ({1'b0, Cx} > {1'b0, active[i].x}) && ({1'b0, Cx} < {1'b0, active[i].x} + {1'b0, active[i].w}) &&
               ({1'b0, Cy} > {1'b0, active[i].y}) && ({1'b0, Cy} < {1'b0, active[i].y} + {1'b0, active[i].h});
    end
  end

  // Walk from the highest index down so the lowest-index hit is the last to overwrite.
  always_comb begin
    sel_color = '0;
`ifdef RGB_MIXER_GRADIENT_EN
    sel_x = '0;
    sel_y = '0;
    sel_mode = 1'b0;
`endif
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_color = active[i].color;
`ifdef RGB_MIXER_GRADIENT_EN
        sel_x = active[i].x;
        sel_y = active[i].y;
        sel_mode = active[i].mode;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cfg_ready <= 1'b1;
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr_sel[i]) shadow[i] <= wr_obj;
        if (frame_start) active[i] <= wr_sel[i] ? wr_obj : shadow[i];
      end
    end
  end

  // Stage 1 captures the winning object's data so a later commit cannot alter in-flight pixels.
  always_comb begin
    pix = s1_color;
`ifdef RGB_MIXER_GRADIENT_EN
    pix = s1_mode ? {COLOR_W'(s1_cx - s1_x), COLOR_W'(s1_cy - s1_y), s1_color[COLOR_W-1:0]} : s1_color;
`endif
    pix = !s1_en ? '0 : !(|s1_hit) ? BG_COLOR : pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hit <= '0;
      s1_en <= 1'b0;
      s1_color <= '0;
`ifdef RGB_MIXER_GRADIENT_EN
      s1_cx <= '0;
      s1_cy <= '0;
      s1_x <= '0;
      s1_y <= '0;
      s1_mode <= 1'b0;
`endif
      out_valid <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      s1_hit <= hit;
      s1_en <= enable;
      s1_color <= sel_color;
`ifdef RGB_MIXER_GRADIENT_EN
      s1_cx <= Cx;
      s1_cy <= Cy;
      s1_x <= sel_x;
      s1_y <= sel_y;
      s1_mode <= sel_mode;
`endif
      out_valid <= s1_en;
      {VGA_R, VGA_G, VGA_B} <= pix;
    end
  end
endmodule
